// File: rtl/cips_pkg.sv
// Shared types for the CIPS instruction processor: opcodes, FSM states and field widths.
package cips_pkg;

  localparam int unsigned OpW = 4;

  typedef enum logic [OpW-1:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpOr   = 4'd2,
    OpAnd  = 4'd3,
    OpXor  = 4'd4,
    OpLdi  = 4'd5,
    OpJmp  = 4'd6,
    OpBz   = 4'd7,
    OpHalt = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } state_e;

endpackage

// File: rtl/cips_if.sv
// Host-side bus of the CIPS core: program loading, start control and execution observation.
interface cips_if #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 8
);
  localparam int unsigned RA = $clog2(NREG);
  localparam int unsigned IW = cips_pkg::OpW + RA + DW;

  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          busy;
  logic          halted;
  logic [AW-1:0] pc_out;
  logic [DW-1:0] result;
  logic          carry;
  logic          zero;
  logic          result_valid;

  modport master (
    output start, prog_we, prog_addr, prog_data,
    input  busy, halted, pc_out, result, carry, zero, result_valid
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data,
    output busy, halted, pc_out, result, carry, zero, result_valid
  );
endinterface

// File: rtl/cips_alu.sv
// Combinational ALU for ADD/SUB/OR/AND/XOR, evaluated at DW+1 bits so the top bit is carry/borrow.
module cips_alu
  import cips_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0]  a_i,
  input  logic [DW-1:0]  b_i,
  input  logic [OpW-1:0] op_i,
  output logic [DW-1:0]  res_o,
  output logic           cout_o
);

  logic [DW:0] sum;

  always_comb begin
    sum = '0;
    case (op_i)
      OpAdd:   sum = {1'b0, a_i} + {1'b0, b_i};
      OpSub:   sum = {1'b0, a_i} - {1'b0, b_i};
      OpOr:    sum = {1'b0, a_i | b_i};
      OpAnd:   sum = {1'b0, a_i & b_i};
      OpXor:   sum = {1'b0, a_i ^ b_i};
      default: sum = '0;
    endcase
  end

  assign res_o  = sum[DW-1:0];
  assign cout_o = sum[DW];

endmodule

// File: rtl/cips_core.sv
// Multi-cycle processor: loadable program memory, register file and an IDLE/FETCH/EXEC/HALT FSM.
module cips_core
  import cips_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 8
) (
  input  logic   clk,
  input  logic   R,
  cips_if.slave  bus
);

  localparam int unsigned RA    = $clog2(NREG);
  localparam int unsigned IW    = OpW + RA + DW;
  localparam int unsigned Depth = 2 ** AW;

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [IW-1:0]  ir_q;
  logic [IW-1:0]  mem_q [Depth];
  logic [DW-1:0]  regs_q [NREG];
  logic [DW-1:0]  result_q, result_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           rv_q, rv_d;

  logic           reg_we;
  logic [DW-1:0]  reg_wd;
  logic [OpW-1:0] op;
  logic [RA-1:0]  rd, rs, rt;
  logic [DW-1:0]  f;
  logic [DW-1:0]  alu_res;
  logic           alu_cout;
  logic           can_load;

  assign op       = ir_q[IW-1 -: OpW];
  assign rd       = ir_q[DW +: RA];
  assign f        = ir_q[DW-1:0];
  assign rs       = f[2*RA-1 -: RA];
  assign rt       = f[RA-1:0];
  assign can_load = (state_q == StIdle) || (state_q == StHalt);

  cips_alu #(
    .DW (DW)
  ) u_alu (
    .a_i    (regs_q[rs]),
    .b_i    (regs_q[rt]),
    .op_i   (op),
    .res_o  (alu_res),
    .cout_o (alu_cout)
  );

  // Program memory survives reset; a write coinciding with start is seen by the following FETCH.
  always_ff @(posedge clk) begin
    if (!R && can_load && bus.prog_we) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StFetch) begin
      ir_q <= mem_q[pc_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    rv_d     = 1'b0;
    reg_we   = 1'b0;
    reg_wd   = '0;
    unique case (state_q)
      StIdle, StHalt: begin
        if (bus.start) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StExec;
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_q + AW'(1);
        case (op)
          OpAdd, OpSub, OpOr, OpAnd, OpXor: begin
            reg_we   = 1'b1;
            reg_wd   = alu_res;
            result_d = alu_res;
            carry_d  = alu_cout;
            zero_d   = (alu_res == '0);
            rv_d     = 1'b1;
          end
          OpLdi: begin
            reg_we   = 1'b1;
            reg_wd   = f;
            result_d = f;
            zero_d   = (f == '0);
            rv_d     = 1'b1;
          end
          OpJmp: pc_d = f[AW-1:0];
          OpBz: begin
            if (zero_q) pc_d = f[AW-1:0];
          end
          OpHalt: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      rv_q     <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      rv_q     <= rv_d;
      if (reg_we) begin
        regs_q[rd] <= reg_wd;
      end
    end
  end

  assign bus.busy         = (state_q == StFetch) || (state_q == StExec);
  assign bus.halted       = (state_q == StHalt);
  assign bus.pc_out       = pc_q;
  assign bus.result       = result_q;
  assign bus.carry        = carry_q;
  assign bus.zero         = zero_q;
  assign bus.result_valid = rv_q;

endmodule

// File: tb/tb_cips_core.sv
// Bench for cips_core: directed and random programs checked against an instruction-level model.
module tb_cips_core;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = 8;
  localparam int IW   = 14;

  logic clk = 1'b0;
  logic R;

  cips_if #(.DW(DW), .NREG(NREG), .AW(AW)) bus ();

  cips_core #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] tmem [256];
  int m_regs [4];
  int m_c, m_z;
  int exp_res[$], exp_c[$], exp_z[$], exp_cyc[$];
  int exp_steps, exp_pc;

  function automatic logic [IW-1:0] enc(input int op, input int rd, input int f);
    return {op[3:0], rd[1:0], f[7:0]};
  endfunction

  function automatic logic [IW-1:0] alu3(input int op, input int rd, input int rs, input int rt);
    return enc(op, rd, rs * 4 + rt);
  endfunction

  task automatic load(input int a, input logic [IW-1:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a[7:0];
    bus.prog_data = d;
    @(posedge clk);
    #1 bus.prog_we = 1'b0;
    tmem[a] = d;
  endtask

  task automatic do_reset();
    R = 1'b1;
    repeat (2) @(posedge clk);
    #1 R = 1'b0;
    foreach (m_regs[i]) m_regs[i] = 0;
    m_c = 0;
    m_z = 0;
  endtask

  // Instruction-set interpreter over the bench's copy of program memory.
  task automatic model_run();
    int pc, k, op, rd, f, a, b, v;
    logic [IW-1:0] ins;
    exp_res.delete(); exp_c.delete(); exp_z.delete(); exp_cyc.delete();
    pc = 0;
    k  = 0;
    forever begin
      ins = tmem[pc];
      op  = int'(ins[13:10]);
      rd  = int'(ins[9:8]);
      f   = int'(ins[7:0]);
      a   = m_regs[f[3:2]];
      b   = m_regs[f[1:0]];
      k++;
      if (k > 1000) break;
      if (op <= 5) begin
        v = 0;
        case (op)
          0: begin v = a + b; m_c = (v > 255) ? 1 : 0; end
          1: begin v = a - b + 256; m_c = (a < b) ? 1 : 0; end
          2: begin v = a | b; m_c = 0; end
          3: begin v = a & b; m_c = 0; end
          4: begin v = a ^ b; m_c = 0; end
          default: v = f;
        endcase
        v = v % 256;
        m_regs[rd] = v;
        m_z = (v == 0) ? 1 : 0;
        exp_res.push_back(v); exp_c.push_back(m_c); exp_z.push_back(m_z);
        exp_cyc.push_back(2 * k);
        pc = (pc + 1) % 256;
      end else if (op == 6) pc = f;
      else if (op == 7) pc = (m_z == 1) ? f : (pc + 1) % 256;
      else if (op == 15) break;
      else pc = (pc + 1) % 256;
    end
    exp_steps = k;
    exp_pc    = pc;
  endtask

  task automatic run_prog(input string name, input bit inject);
    int idx, hcyc;
    model_run();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    idx  = 0;
    hcyc = -1;
    for (int cyc = 1; cyc <= 2 * exp_steps + 10; cyc++) begin
      if (inject && cyc == 3) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = '0;
        bus.prog_data = ~tmem[0];
      end else if (inject && cyc == 4) begin
        bus.prog_we = 1'b0;
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.busy !== (cyc < 2 * exp_steps)) begin
        bad++;
        $display("FAIL %s busy cyc=%0d got=%0b", name, cyc, bus.busy);
      end
      if (bus.result_valid) begin
        total++;
        if (idx >= exp_res.size()) begin
          bad++;
          $display("FAIL %s extra_valid cyc=%0d got=%0d", name, cyc, bus.result);
        end else if (bus.result !== exp_res[idx][7:0] || bus.carry !== exp_c[idx][0] ||
                     bus.zero !== exp_z[idx][0] || cyc != exp_cyc[idx]) begin
          bad++;
          $display("FAIL %s result#%0d got=%0d c=%0b z=%0b cyc=%0d want=%0d c=%0d z=%0d cyc=%0d",
                   name, idx, bus.result, bus.carry, bus.zero, cyc,
                   exp_res[idx], exp_c[idx], exp_z[idx], exp_cyc[idx]);
        end
        idx++;
      end
      if (bus.halted) begin
        hcyc = cyc;
        break;
      end
    end
    total++;
    if (hcyc != 2 * exp_steps) begin
      bad++;
      $display("FAIL %s halt_cycle got=%0d want=%0d", name, hcyc, 2 * exp_steps);
    end
    total++;
    if (idx != exp_res.size()) begin
      bad++;
      $display("FAIL %s valid_count got=%0d want=%0d", name, idx, exp_res.size());
    end
    total++;
    if (bus.pc_out !== exp_pc[7:0]) begin
      bad++;
      $display("FAIL %s final_pc got=%0d want=%0d", name, bus.pc_out, exp_pc);
    end
    total++;
    if (bus.carry !== m_c[0] || bus.zero !== m_z[0]) begin
      bad++;
      $display("FAIL %s final_flags got c=%0b z=%0b want c=%0d z=%0d",
               name, bus.carry, bus.zero, m_c, m_z);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.busy, bus.halted, bus.result_valid, bus.carry, bus.zero} !== 5'b0) begin
      bad++;
      $display("FAIL reset_status got=%b want=00000",
               {bus.busy, bus.halted, bus.result_valid, bus.carry, bus.zero});
    end
    total++;
    if (bus.pc_out !== 8'd0 || bus.result !== 8'd0) begin
      bad++;
      $display("FAIL reset_regs got pc=%0d result=%0d want 0/0", bus.pc_out, bus.result);
    end
  endtask

  task automatic test_basic();
    load(0, enc(5, 0, 200));
    load(1, enc(5, 1, 100));
    load(2, alu3(0, 2, 0, 1));
    load(3, enc(15, 0, 0));
    run_prog("basic", 1'b0);
    total++;
    if (bus.result !== 8'd44 || bus.carry !== 1'b1 || bus.pc_out !== 8'd3 || !bus.halted) begin
      bad++;
      $display("FAIL basic_const got r=%0d c=%0b pc=%0d h=%0b want 44/1/3/1",
               bus.result, bus.carry, bus.pc_out, bus.halted);
    end
  endtask

  task automatic test_sub();
    load(2, alu3(1, 3, 1, 0));
    load(3, alu3(1, 3, 0, 1));
    load(4, enc(15, 0, 0));
    run_prog("sub", 1'b0);
    total++;
    if (bus.result !== 8'd100 || bus.carry !== 1'b0 || bus.zero !== 1'b0) begin
      bad++;
      $display("FAIL sub_const got r=%0d c=%0b z=%0b want 100/0/0",
               bus.result, bus.carry, bus.zero);
    end
  endtask

  task automatic test_branch();
    load(0, alu3(4, 0, 0, 0));
    load(1, enc(7, 0, 10));
    load(2, enc(5, 1, 3));
    load(3, enc(15, 0, 0));
    load(10, enc(5, 1, 7));
    load(11, enc(15, 0, 0));
    run_prog("bz_taken", 1'b0);
    load(0, enc(5, 0, 1));
    run_prog("bz_fall", 1'b0);
  endtask

  task automatic test_jmp_wrap();
    load(0, alu3(4, 0, 0, 0));
    load(1, enc(15, 0, 0));
    run_prog("wrap_prep", 1'b0);
    load(0, enc(7, 0, 254));
    load(254, enc(6, 0, 255));
    load(255, enc(5, 0, 1));
    run_prog("jmp_wrap", 1'b0);
  endtask

  task automatic test_abort();
    load(0, enc(5, 0, 200));
    load(1, enc(5, 1, 100));
    load(2, alu3(0, 2, 0, 1));
    load(3, alu3(0, 3, 3, 2));
    load(4, enc(15, 0, 0));
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 R = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({bus.result_valid, bus.busy, bus.halted, bus.carry, bus.zero} !== 5'b0 ||
        bus.result !== 8'd0 || bus.pc_out !== 8'd0) begin
      bad++;
      $display("FAIL abort_state got rv=%0b busy=%0b h=%0b c=%0b z=%0b r=%0d pc=%0d want zeros",
               bus.result_valid, bus.busy, bus.halted, bus.carry, bus.zero, bus.result,
               bus.pc_out);
    end
    R = 1'b0;
    foreach (m_regs[i]) m_regs[i] = 0;
    m_c = 0;
    m_z = 0;
    run_prog("abort_rerun", 1'b0);
  endtask

  task automatic test_busy_write_nop();
    load(0, enc(5, 0, 10));
    load(1, enc(5, 1, 20));
    load(2, alu3(1, 2, 0, 1));
    load(3, enc(9, 2, 255));
    load(4, enc(15, 0, 0));
    run_prog("busy_write", 1'b1);
    run_prog("busy_rerun", 1'b0);
  endtask

  task automatic test_random();
    int op, f;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 16; a++) begin
        op = int'($urandom_range(0, 14));
        f  = int'($urandom_range(0, 255));
        if (op == 6 || op == 7) f = int'($urandom_range(a + 1, 16));
        load(a, enc(op, int'($urandom_range(0, 3)), f));
      end
      load(16, enc(15, 0, 0));
      run_prog($sformatf("random%0d", it), 1'b0);
    end
  endtask

  initial begin
    R             = 1'b1;
    bus.start     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    test_reset();
    test_basic();
    test_sub();
    test_branch();
    test_jmp_wrap();
    test_abort();
    test_busy_write_nop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
